// File: rtl/impor_feeder.sv
// -----------------------------------------------------------------------------
// impor_feeder
//   Upstream feeder for the IMPOR core. Host-written 3-bit symbols and their
//   per-frame modes are queued in a FIFO. Complete frames are handed to IMPOR
//   one at a time, and only while IMPOR reports ready. After a frame is sent,
//   the feeder waits for the falling edge of IMPOR's out_valid before it
//   starts the next frame.
//
// Parameters
//   DEPTH    FIFO entries (power of two, 2..64); also the maximum frame length.
//   TIMEOUT  WAIT-state watchdog limit in cycles (timeout build only).
//
// Optional feature
//   IMPOR_FEEDER_TIMEOUT_EN  When defined, a watchdog runs in WAIT. If the
//                            completion edge has not arrived after TIMEOUT
//                            cycles, o_err pulses for one cycle and the FSM
//                            returns to IDLE. When undefined, WAIT waits
//                            indefinitely and o_err is tied low.
//
// Ports
//   i_clk          clock; all logic on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_wr_valid     host write strobe
//   i_wr_data[2:0] symbol
//   i_wr_mode[2:0] mode; only the value on a frame's first entry is used
//   i_wr_last      marks the final symbol of a frame
//   o_wr_ready     FIFO not full (combinational)
//   i_ready        IMPOR idle/accepting; sampled only in IDLE
//   i_out_valid    IMPOR result valid; its falling edge ends a frame
//   o_in[2:0]      symbol to IMPOR (registered)
//   o_mode[2:0]    mode to IMPOR (registered; nonzero only on the first symbol)
//   o_in_valid     symbol strobe to IMPOR (registered)
//   o_busy         FSM is not in IDLE (registered)
//   o_frame_cnt    completed frames, wraps at 255
//   o_err          one-cycle watchdog timeout pulse
//
// FSM states
//   IDLE | waiting for ready and a complete (or forced-flush) frame
//   SEND | popping one entry per cycle toward IMPOR
//   WAIT | frame sent; waiting for the out_valid falling edge
// -----------------------------------------------------------------------------
module impor_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_valid,
  input  logic [2:0] i_wr_data,
  input  logic [2:0] i_wr_mode,
  input  logic       i_wr_last,
  output logic       o_wr_ready,
  input  logic       i_ready,
  input  logic       i_out_valid,
  output logic [2:0] o_in,
  output logic [2:0] o_mode,
  output logic       o_in_valid,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt,
  output logic       o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("impor_feeder: DEPTH must be a power of two in 2..64 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage: entry = {last, mode, data}
  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pend;
  logic [CW-1:0] r_sym_cnt;

  logic [6:0]    w_head;
  logic          w_head_last;
  logic [2:0]    w_head_mode;
  logic [2:0]    w_head_data;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_avail;
  logic          w_fall;
  logic          w_timeout;

  logic [2:0]    w_in_d;
  logic [2:0]    w_mode_d;
  logic          w_in_valid_d;

  logic [2:0]    r_in;
  logic [2:0]    r_mode;
  logic          r_in_valid;
  logic          r_busy;
  logic [7:0]    r_frame_cnt;
  logic          r_ov_prev;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_last = w_head[6];
  assign w_head_mode = w_head[5:3];
  assign w_head_data = w_head[2:0];

  // wr_ready deliberately ignores a same-cycle pop: a full FIFO refuses the write.
  assign w_full     = (r_count == CW'(DEPTH));
  assign o_wr_ready = ~w_full;
  assign w_push     = i_wr_valid & ~w_full;

  // A full FIFO with no complete frame inside is flushed as one DEPTH-symbol frame.
  assign w_avail = (r_pend != '0) | w_full;

  assign w_fall = (r_state == S_WAIT) & r_ov_prev & ~i_out_valid;

  // ---------------------------------------------------------------------------
  // FIFO and pending-frame bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pend   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_wr_last, i_wr_mode, i_wr_data};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_push & i_wr_last, w_pop & w_head_last})
        2'b10:   r_pend <= r_pend + CW'(1);
        2'b01:   r_pend <= r_pend - CW'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register (busy tracks the next state so it is aligned with it)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_ready && w_avail) begin
          w_state_nxt = w_head_last ? S_WAIT : S_SEND;
        end
      end
      S_SEND: begin
        // r_sym_cnt counts entries already popped; this pop is number r_sym_cnt+1.
        if (w_head_last || (r_sym_cnt == CW'(DEPTH - 1))) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_fall || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (values registered into the IMPOR-facing outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pop        = 1'b0;
    w_in_d       = 3'd0;
    w_mode_d     = 3'd0;
    w_in_valid_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ready && w_avail) begin
          w_pop        = 1'b1;
          w_in_d       = w_head_data;
          w_mode_d     = w_head_mode;
          w_in_valid_d = 1'b1;
        end
      end
      S_SEND: begin
        w_pop        = 1'b1;
        w_in_d       = w_head_data;
        w_in_valid_d = 1'b1;
      end
      default: begin
        w_pop        = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, frame length tracking and completion detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in        <= 3'd0;
      r_mode      <= 3'd0;
      r_in_valid  <= 1'b0;
      r_sym_cnt   <= '0;
      r_frame_cnt <= 8'd0;
      r_ov_prev   <= 1'b0;
    end else begin
      r_in       <= w_in_d;
      r_mode     <= w_mode_d;
      r_in_valid <= w_in_valid_d;
      if (w_pop) begin
        r_sym_cnt <= (r_state == S_IDLE) ? CW'(1) : r_sym_cnt + CW'(1);
      end
      if (w_fall) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      // Held low outside WAIT so only a level seen during WAIT can form an edge;
      // out_valid already high on WAIT entry becomes the "previous 1" next cycle.
      r_ov_prev <= (r_state == S_WAIT) ? i_out_valid : 1'b0;
    end
  end

`ifdef IMPOR_FEEDER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] r_wait_cnt;

  // Holds the number of completed WAIT cycles; the FSM leaves WAIT at
  // TIMEOUT-1 at the latest, so the counter never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // A completion edge in the final cycle wins over the timeout.
  assign w_timeout = (r_state == S_WAIT) & ~w_fall & (r_wait_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign o_in        = r_in;
  assign o_mode      = r_mode;
  assign o_in_valid  = r_in_valid;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err       = w_timeout;

endmodule

// File: tb/tb_impor_feeder.sv
module tb_impor_feeder;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [2:0] wr_data;
  logic [2:0] wr_mode;
  logic       wr_last;
  logic       wr_ready;
  logic       ready;
  logic       out_valid;
  logic [2:0] in_sym;
  logic [2:0] mode;
  logic       in_valid;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  impor_feeder #(.DEPTH(16), .TIMEOUT(20)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_valid  (wr_valid),
    .i_wr_data   (wr_data),
    .i_wr_mode   (wr_mode),
    .i_wr_last   (wr_last),
    .o_wr_ready  (wr_ready),
    .i_ready     (ready),
    .i_out_valid (out_valid),
    .o_in        (in_sym),
    .o_mode      (mode),
    .o_in_valid  (in_valid),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [2:0] wd;
    logic [2:0] wm;
    logic       wl;
    logic       rdy;
    logic       ov;
    logic       e_iv;
    logic [2:0] e_in;
    logic [2:0] e_mode;
    logic       e_busy;
    logic [7:0] e_fc;
    logic       e_wrdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wv, input logic [2:0] wd, input logic [2:0] wm,
                     input logic wl, input logic rdy, input logic ov,
                     input logic e_iv, input logic [2:0] e_in, input logic [2:0] e_mode,
                     input logic e_busy, input logic [7:0] e_fc, input logic e_wrdy);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wm = wm; v.wl = wl; v.rdy = rdy; v.ov = ov;
    v.e_iv = e_iv; v.e_in = e_in; v.e_mode = e_mode;
    v.e_busy = e_busy; v.e_fc = e_fc; v.e_wrdy = e_wrdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [2:0] d, input logic [2:0] m, input logic l);
    wr_valid = v;
    wr_data  = d;
    wr_mode  = m;
    wr_last  = l;
  endtask

  task automatic chk_out(input string tag, input logic iv, input logic [2:0] s,
                         input logic [2:0] m, input logic b, input logic [7:0] fc);
    chk({tag, "_in_valid"}, in_valid, iv);
    chk({tag, "_in"}, in_sym, s);
    chk({tag, "_mode"}, mode, m);
    chk({tag, "_busy"}, busy, b);
    chk({tag, "_frame_cnt"}, frame_cnt, fc);
  endtask

  initial begin
    rst_n     = 1'b0;
    ready     = 1'b0;
    out_valid = 1'b0;
    set_wr(0, 0, 0, 0);

    // ---------------- vector table ----------------
    // Frame 1: 1,2,3 mode 5; later-entry modes must not leak out.
    add(1,1,5,0,1,0, 0,0,0,0,0,1);
    add(1,2,7,0,1,0, 0,0,0,0,0,1);
    add(1,3,6,1,1,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0, 1,1,5,1,0,1);
    add(0,0,0,0,1,0, 1,2,0,1,0,1);
    add(0,0,0,0,1,0, 1,3,0,1,0,1);
    add(0,0,0,0,1,0, 0,0,0,1,0,1);
    add(0,0,0,0,1,1, 0,0,0,1,0,1);
    add(0,0,0,0,1,0, 0,0,0,0,1,1);
    add(0,0,0,0,1,0, 0,0,0,0,1,1);
    // Two frames (2 and 4 symbols) queued while ready is low.
    add(1,4,2,0,0,0, 0,0,0,0,1,1);
    add(1,5,0,1,0,0, 0,0,0,0,1,1);
    add(1,6,3,0,0,0, 0,0,0,0,1,1);
    add(1,7,0,0,0,0, 0,0,0,0,1,1);
    add(1,1,0,0,0,0, 0,0,0,0,1,1);
    add(1,2,0,1,0,0, 0,0,0,0,1,1);
    for (int i = 0; i < 10; i++) add(0,0,0,0,0,0, 0,0,0,0,1,1);
    add(0,0,0,0,1,0, 1,4,2,1,1,1);
    add(0,0,0,0,0,0, 1,5,0,1,1,1);
    add(0,0,0,0,0,0, 0,0,0,1,1,1);
    add(0,0,0,0,0,1, 0,0,0,1,1,1);
    add(0,0,0,0,1,0, 0,0,0,0,2,1);
    add(0,0,0,0,1,0, 1,6,3,1,2,1);
    add(0,0,0,0,0,0, 1,7,0,1,2,1);
    add(0,0,0,0,0,0, 1,1,0,1,2,1);
    add(0,0,0,0,0,0, 1,2,0,1,2,1);
    add(0,0,0,0,0,0, 0,0,0,1,2,1);
    add(0,0,0,0,0,1, 0,0,0,1,2,1);
    add(0,0,0,0,0,0, 0,0,0,0,3,1);

    // ---------------- reset values ----------------
    #12;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---------------- table-driven part ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      set_wr(vecs[i].wv, vecs[i].wd, vecs[i].wm, vecs[i].wl);
      ready     = vecs[i].rdy;
      out_valid = vecs[i].ov;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_iv, vecs[i].e_in, vecs[i].e_mode,
              vecs[i].e_busy, vecs[i].e_fc);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].e_wrdy);
      chk($sformatf("vec%0d_err", i), err, 0);
    end
    set_wr(0, 0, 0, 0);
    ready     = 1'b0;
    out_valid = 1'b0;

    // ---------------- forced flush of a full FIFO ----------------
    for (int i = 0; i < 16; i++) begin
      set_wr(1, 3'(i % 8), (i == 0) ? 3'd1 : 3'd2, 0);
      tick();
    end
    chk("flush_full_wr_ready", wr_ready, 0);
    chk("flush_full_in_valid", in_valid, 0);
    set_wr(1, 6, 0, 0);            // refused: FIFO full
    tick();
    chk("flush_refused_wr_ready", wr_ready, 0);
    ready = 1'b1;
    set_wr(1, 7, 3, 1);            // refused: wr_ready low despite same-cycle pop
    tick();
    chk_out("flush_pop0", 1, 0, 1, 1, 3);
    chk("flush_pop0_wr_ready", wr_ready, 1);
    ready = 1'b0;
    set_wr(1, 5, 4, 1);            // accepted together with a pop
    tick();
    chk_out("flush_pop1", 1, 1, 0, 1, 3);
    chk("flush_pop1_wr_ready", wr_ready, 1);
    set_wr(0, 0, 0, 0);
    for (int k = 2; k < 16; k++) begin
      tick();
      chk_out($sformatf("flush_pop%0d", k), 1, 3'(k % 8), 0, 1, 3);
    end
    tick();
    chk_out("flush_wait", 0, 0, 0, 1, 3);
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    tick();
    chk_out("flush_done", 0, 0, 0, 0, 4);
    ready = 1'b1;
    tick();
    chk_out("single_sym", 1, 5, 4, 1, 4);
    tick();
    chk_out("single_wait", 0, 0, 0, 1, 4);
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    tick();
    chk_out("single_done", 0, 0, 0, 0, 5);
    chk("single_done_wr_ready", wr_ready, 1);

    // ---------------- reset mid-frame ----------------
    ready = 1'b0;
    set_wr(1, 1, 6, 0); tick();
    set_wr(1, 2, 0, 0); tick();
    set_wr(1, 3, 0, 0); tick();
    set_wr(1, 4, 0, 1); tick();
    set_wr(0, 0, 0, 0);
    ready = 1'b1;
    tick();
    chk_out("rstmid_sym1", 1, 1, 6, 1, 5);
    tick();
    chk_out("rstmid_sym2", 1, 2, 0, 1, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rstmid_async", 0, 0, 0, 0, 0);
    chk("rstmid_async_wr_ready", wr_ready, 1);
    chk("rstmid_async_err", err, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("rstmid_idle%0d", k), 0, 0, 0, 0, 0);
    end
    set_wr(1, 7, 2, 1);
    tick();
    set_wr(0, 0, 0, 0);
    tick();
    chk_out("rstmid_newframe", 1, 7, 2, 1, 0);
    tick();
    chk_out("rstmid_newwait", 0, 0, 0, 1, 0);
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    tick();
    chk_out("rstmid_newdone", 0, 0, 0, 0, 1);

`ifdef IMPOR_FEEDER_TIMEOUT_EN
    // ---------------- WAIT watchdog (TIMEOUT=20) ----------------
    set_wr(1, 3, 1, 1);
    tick();
    set_wr(0, 0, 0, 0);
    tick();
    chk_out("to_wait1", 1, 3, 1, 1, 1);
    chk("to_wait1_err", err, 0);
    for (int k = 2; k <= 20; k++) begin
      tick();
      chk($sformatf("to_wait%0d_err", k), err, (k == 20) ? 1 : 0);
      chk($sformatf("to_wait%0d_busy", k), busy, 1);
    end
    ready = 1'b0;
    tick();
    chk_out("to_after", 0, 0, 0, 0, 1);
    chk("to_after_err", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
